// File: rtl/barrett_for_463.sv
// barrett_for_463 -- reduces a 17-bit unsigned operand modulo 463 by Barrett
// reduction. A multiply-shift quotient estimate is followed by at most two
// conditional subtractions, so no divider is needed.
//
// Ports:
//   clk     in   1   rising-edge clock
//   rst     in   1   asynchronous active-high reset (clears dout_q / vld_q)
//   din_a   in   17  unsigned operand, 0..131071
//   din_vld in   1   din_a valid, sampled on the rising edge of clk
//   dout_r  out  9   combinational din_a mod 463 (zero latency)
//   dout_q  out  9   dout_r registered, one cycle of latency
//   vld_q   out  1   dout_q valid
module barrett_for_463 #(
  parameter int Q  = 463,  // modulus, 2^8 < Q < 2^9
  parameter int NI = 17,   // input width
  parameter int NO = 9,    // output width
  parameter int K  = 18,   // Barrett shift
  parameter int M  = 566   // floor(2^K / Q)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [NI-1:0] din_a,
  input  logic          din_vld,
  output logic [NO-1:0] dout_r,
  output logic [NO-1:0] dout_q,
  output logic          vld_q
);

  // M fits in 10 bits, so the product needs NI + 10 bits to avoid wrapping.
  localparam int MW = 10;
  localparam int PW = NI + MW;
  // One extra bit over the input holds the remainder before correction.
  localparam int RW = NI + 1;

  logic [PW-1:0] prod;
  logic [NO-1:0] q_est;
  logic [RW-1:0] q_times_mod;
  logic [RW-1:0] rem0;
  logic [RW-1:0] rem1;
  logic [RW-1:0] rem2;
  logic [NO-1:0] dout_d;
  logic          vld_d;

  // Subtract the modulus once when the value is not yet below it.
  function automatic logic [RW-1:0] sub_mod_once(input logic [RW-1:0] x);
    if (x >= RW'(Q)) begin
      return x - RW'(Q);
    end
    return x;
  endfunction

  // The estimate never exceeds the true quotient because M/2^K < 1/Q. The
  // subtraction therefore cannot underflow. The estimate can be low by at
  // most 2, so two corrections always bring the remainder into [0, Q-1].
  always_comb begin
    prod        = PW'(din_a) * PW'(M);
    q_est       = NO'(prod >> K);
    q_times_mod = RW'(q_est) * RW'(Q);
    rem0        = RW'(din_a) - q_times_mod;
    rem1        = sub_mod_once(rem0);
    rem2        = sub_mod_once(rem1);
    dout_r      = NO'(rem2);
    dout_d      = dout_r;
    vld_d       = din_vld;
  end

  // ---- stage boundary: combinational result -> registered output ----
  // Reset clears both data and valid, so a result in flight is discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      dout_q <= dout_d;
      vld_q  <= vld_d;
    end
  end

endmodule

// File: tb/tb_barrett_for_463.sv
module tb_barrett_for_463;

  logic        clk;
  logic        rst;
  logic [16:0] din_a;
  logic        din_vld;
  logic [8:0]  dout_r;
  logic [8:0]  dout_q;
  logic        vld_q;

  int n_checks = 0;
  int n_fail   = 0;

  barrett_for_463 dut (
    .clk     (clk),
    .rst     (rst),
    .din_a   (din_a),
    .din_vld (din_vld),
    .dout_r  (dout_r),
    .dout_q  (dout_q),
    .vld_q   (vld_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Directed combinational vectors with hand-computed remainders.
  int vec_in  [10] = '{463, 464, 926, 925, 131071, 131029, 131028, 500, 1000, 77};
  int vec_exp [10] = '{0,   1,   0,   462, 42,     0,      462,    37,  74,   77};

  initial begin
    rst     = 1'b1;
    din_a   = '0;
    din_vld = 1'b0;
    #1;
    check_eq("reset_dout_q", 32'(dout_q), 0);
    check_eq("reset_vld_q",  32'(vld_q),  0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Values below the modulus pass through unchanged.
    for (int i = 0; i < 463; i++) begin
      din_a = 17'(i);
      #10;
      check_eq("passthru", 32'(dout_r), 32'(i));
    end

    for (int i = 0; i < 10; i++) begin
      din_a = 17'(vec_in[i]);
      #10;
      check_eq($sformatf("vec_%0d", vec_in[i]), 32'(dout_r), 32'(vec_exp[i]));
    end

    // Every input against the software remainder.
    for (int i = 0; i < 131072; i++) begin
      din_a = 17'(i);
      #1;
      check_eq("exhaustive", 32'(dout_r), 32'(i % 463));
    end

    // Pipelined stream: 500, 1000, 77 on consecutive cycles.
    @(negedge clk);
    din_vld = 1'b0;
    din_a   = 17'd0;
    @(negedge clk);
    check_eq("pipe_idle_vld", 32'(vld_q), 0);
    din_a = 17'd500;  din_vld = 1'b1;
    @(negedge clk);
    check_eq("pipe0_dout", 32'(dout_q), 37);
    check_eq("pipe0_vld",  32'(vld_q),  1);
    din_a = 17'd1000;
    @(negedge clk);
    check_eq("pipe1_dout", 32'(dout_q), 74);
    check_eq("pipe1_vld",  32'(vld_q),  1);
    din_a = 17'd77;
    @(negedge clk);
    check_eq("pipe2_dout", 32'(dout_q), 77);
    check_eq("pipe2_vld",  32'(vld_q),  1);
    din_a = 17'd5;  din_vld = 1'b0;
    @(negedge clk);
    check_eq("pipe_tail_vld0", 32'(vld_q), 0);
    check_eq("pipe_tail_dout", 32'(dout_q), 5);
    @(negedge clk);
    check_eq("pipe_tail_vld1", 32'(vld_q), 0);

    // Reset asserted mid-stream.
    din_a = 17'd1000;  din_vld = 1'b1;
    @(negedge clk);
    check_eq("mid_pre_dout", 32'(dout_q), 74);
    din_a = 17'd500;
    @(posedge clk);
    #1;
    check_eq("mid_inflight_dout", 32'(dout_q), 37);
    check_eq("mid_inflight_vld",  32'(vld_q),  1);
    rst = 1'b1;
    din_a = 17'd926;
    #1;
    check_eq("rst_async_dout", 32'(dout_q), 0);
    check_eq("rst_async_vld",  32'(vld_q),  0);
    check_eq("rst_comb_dout_r", 32'(dout_r), 0);
    din_a = 17'd925;
    #1;
    check_eq("rst_comb_follow", 32'(dout_r), 462);
    @(posedge clk);
    #1;
    check_eq("rst_hold_vld", 32'(vld_q), 0);
    @(negedge clk);
    rst = 1'b0;  din_vld = 1'b0;
    @(negedge clk);
    check_eq("post_rst_vld",  32'(vld_q),  0);
    check_eq("post_rst_dout", 32'(dout_q), 462);
    din_a = 17'd464;  din_vld = 1'b1;
    @(negedge clk);
    check_eq("resume_dout", 32'(dout_q), 1);
    check_eq("resume_vld",  32'(vld_q),  1);
    din_vld = 1'b0;
    @(negedge clk);
    check_eq("resume_end_vld", 32'(vld_q), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
